// File: rtl/spgd_dither_sequencer.sv
// One SPGD dither measurement: DAC to base+amp, settle, average, then base-amp, settle, average,
// and report J+, J- and their full-precision difference.
module spgd_dither_sequencer #(
  parameter int ADC_WIDTH     = 12,
  parameter int DAC_WIDTH     = 14,
  parameter int SETTLE_CYCLES = 256,
  parameter int AVG_TIMEOUT   = 4096
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic signed [DAC_WIDTH-1:0] DAC_BASE,
  input  logic        [DAC_WIDTH-2:0] DITHER_AMP,
  output logic signed [DAC_WIDTH-1:0] DAC_OUT,
  output logic                        AVG_RST,
  input  logic                        AVG_DONE,
  input  logic signed [ADC_WIDTH-1:0] AVG_DATA,
  output logic signed [ADC_WIDTH-1:0] J_PLUS,
  output logic signed [ADC_WIDTH-1:0] J_MINUS,
  output logic signed [ADC_WIDTH:0]   DELTA_J,
  output logic                        RESULT_VALID,
  output logic                        BUSY,
  output logic                        TIMEOUT_ERR
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(AVG_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] AVG_LAST    = TW'(AVG_TIMEOUT - 1);
  localparam logic [TW-1:0] STALE_SKIP  = TW'(2);
  localparam logic signed [DAC_WIDTH:0] DAC_MAX = {2'b00, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [DAC_WIDTH:0] DAC_MIN = {2'b11, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETTLE_P, AVG_P, SETTLE_M, AVG_M, REPORT} state_t;

  state_t                      state;
  logic signed [DAC_WIDTH-1:0] base_q;
  logic        [DAC_WIDTH-2:0] amp_q;
  logic        [SW-1:0]        settle_cnt;
  logic        [TW-1:0]        avg_cnt;

  // One extra bit of headroom so base +/- amp cannot wrap before clamping.
  function automatic logic signed [DAC_WIDTH-1:0] sat_dither(
    input logic signed [DAC_WIDTH-1:0] base,
    input logic        [DAC_WIDTH-2:0] amp,
    input logic                        minus
  );
    logic signed [DAC_WIDTH:0] base_x;
    logic signed [DAC_WIDTH:0] amp_x;
    logic signed [DAC_WIDTH:0] sum;
    base_x = $signed({base[DAC_WIDTH-1], base});
    amp_x  = $signed({2'b00, amp});
    sum    = minus ? (base_x - amp_x) : (base_x + amp_x);
    if (sum > DAC_MAX)      return DAC_MAX[DAC_WIDTH-1:0];
    else if (sum < DAC_MIN) return DAC_MIN[DAC_WIDTH-1:0];
    else                    return sum[DAC_WIDTH-1:0];
  endfunction

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      base_q       <= '0;
      amp_q        <= '0;
      settle_cnt   <= '0;
      avg_cnt      <= '0;
      DAC_OUT      <= '0;
      AVG_RST      <= 1'b1;
      J_PLUS       <= '0;
      J_MINUS      <= '0;
      DELTA_J      <= '0;
      RESULT_VALID <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads pre-edge register values.
      RESULT_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          DAC_OUT <= base_q;
          AVG_RST <= 1'b1;
          if (START) begin
            base_q      <= DAC_BASE;
            amp_q       <= DITHER_AMP;
            TIMEOUT_ERR <= 1'b0;
            DAC_OUT     <= sat_dither(DAC_BASE, DITHER_AMP, 1'b0);
            settle_cnt  <= '0;
            state       <= SETTLE_P;
          end
        end
        SETTLE_P, SETTLE_M: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            avg_cnt    <= '0;
            AVG_RST    <= 1'b0;
            state      <= (state == SETTLE_P) ? AVG_P : AVG_M;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        AVG_P, AVG_M: begin
          // The first two cycles may still see DONE left over from the previous average.
          if (avg_cnt >= STALE_SKIP && AVG_DONE) begin
            AVG_RST <= 1'b1;
            if (state == AVG_P) begin
              J_PLUS  <= AVG_DATA;
              DAC_OUT <= sat_dither(base_q, amp_q, 1'b1);
              state   <= SETTLE_M;
            end else begin
              J_MINUS      <= AVG_DATA;
              DELTA_J      <= {J_PLUS[ADC_WIDTH-1], J_PLUS} - {AVG_DATA[ADC_WIDTH-1], AVG_DATA};
              RESULT_VALID <= 1'b1;
              DAC_OUT      <= base_q;
              state        <= REPORT;
            end
          end else if (avg_cnt == AVG_LAST) begin
            TIMEOUT_ERR <= 1'b1;
            DAC_OUT     <= base_q;
            AVG_RST     <= 1'b1;
            state       <= IDLE;
          end else begin
            avg_cnt <= avg_cnt + 1'b1;
          end
        end
        REPORT: begin
          DAC_OUT <= base_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// Directed bench for spgd_dither_sequencer with a behavioural averager whose DONE rises
// N cycles after AVG_RST falls and drops as soon as AVG_RST returns high.
module tb_spgd_dither_sequencer;

  localparam int S  = 4;
  localparam int TO = 64;
  localparam int N  = 8;
  localparam int LAT = 2 * S + 2 * (N + 1) + 1;

  logic               clk, rst, start;
  logic signed [13:0] dac_base;
  logic        [12:0] dither_amp;
  logic signed [13:0] dac_out;
  logic               avg_rst, avg_done;
  logic signed [11:0] avg_data, j_plus, j_minus;
  logic signed [12:0] delta_j;
  logic               result_valid, busy, timeout_err;

  int tests = 0;
  int fails = 0;

  int                 mcnt;
  logic               mdone;
  bit                 never_done = 0;
  bit                 stale_done = 0;
  logic signed [13:0] base_ref = '0;
  logic signed [11:0] jp_val = '0;
  logic signed [11:0] jm_val = '0;

  spgd_dither_sequencer #(
    .ADC_WIDTH(12), .DAC_WIDTH(14), .SETTLE_CYCLES(S), .AVG_TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .DAC_BASE(dac_base), .DITHER_AMP(dither_amp),
    .DAC_OUT(dac_out), .AVG_RST(avg_rst), .AVG_DONE(avg_done), .AVG_DATA(avg_data),
    .J_PLUS(j_plus), .J_MINUS(j_minus), .DELTA_J(delta_j), .RESULT_VALID(result_valid),
    .BUSY(busy), .TIMEOUT_ERR(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avg_rst) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (!never_done && !mdone) begin
      if (mcnt == N - 1) mdone <= 1'b1;
      else               mcnt  <= mcnt + 1;
    end
  end

  assign avg_done = mdone | stale_done;
  assign avg_data = stale_done ? 12'sd170 : ((dac_out > base_ref) ? jp_val : jm_val);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int base, input int amp, input int jp, input int jm);
    dac_base   = 14'(base);
    base_ref   = 14'(base);
    dither_amp = 13'(amp);
    jp_val     = 12'(jp);
    jm_val     = 12'(jm);
  endtask

  // Pulses START and steps until RESULT_VALID; lat counts edges from the START edge.
  task automatic run(input bit spam, output int lat, output int dac_p, output int dac_m,
                     output bit seen);
    int l;
    start = 1'b1;
    step();
    start = 1'b0;
    dac_p = dac_out;
    dac_m = 0;
    seen  = 0;
    for (l = 1; l < 200; l++) begin
      if (l == S + N + 2) dac_m = dac_out;
      if (result_valid) begin
        seen = 1;
        break;
      end
      if (spam) begin
        start = (l % 5 == 0);
        if (start) dac_base = -14'sd3000;
      end
      step();
    end
    start = 1'b0;
    lat = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    setup(123, 7, 0, 0);
    step(); step();
    rst = 1'b0; start = 1'b0;
    tests++;
    if (dac_out !== 14'sd0 || avg_rst !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 ||
        timeout_err !== 1'b0 || j_plus !== 12'sd0 || j_minus !== 12'sd0 || delta_j !== 13'sd0) begin
      fails++;
      $display("FAIL reset: dac=%0d avg_rst=%b busy=%b rv=%b te=%b jp=%0d jm=%0d dj=%0d, want all 0 except avg_rst=1",
               dac_out, avg_rst, busy, result_valid, timeout_err, j_plus, j_minus, delta_j);
    end
  endtask

  task automatic test_basic();
    int lat, dp, dm;
    bit seen;
    setup(100, 50, 300, -200);
    run(0, lat, dp, dm, seen);
    tests++;
    if (!seen || lat != LAT) begin
      fails++; $display("FAIL basic_latency: seen=%0d lat=%0d, want 1 %0d", seen, lat, LAT);
    end
    tests++;
    if (dp != 150 || dm != 50 || dac_out !== 14'sd100) begin
      fails++; $display("FAIL basic_dac: %0d %0d %0d, want 150 50 100", dp, dm, dac_out);
    end
    tests++;
    if (j_plus !== 12'sd300 || j_minus !== -12'sd200 || delta_j !== 13'sd500) begin
      fails++; $display("FAIL basic_results: %0d %0d %0d, want 300 -200 500", j_plus, j_minus, delta_j);
    end
    // START during REPORT must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL report_pulse: rv=%b busy=%b, want 0 0", result_valid, busy);
    end
    step();
    tests++;
    if (busy !== 1'b0 || dac_out !== 14'sd100) begin
      fails++; $display("FAIL report_start_ignored: busy=%b dac=%0d, want 0 100", busy, dac_out);
    end
  endtask

  task automatic test_saturation();
    int lat, dp, dm;
    bit seen;
    setup(8100, 200, 5, 6);
    run(0, lat, dp, dm, seen);
    tests++;
    if (!seen || dp != 8191 || dm != 7900) begin
      fails++; $display("FAIL sat_pos: seen=%0d dac %0d %0d, want 1 8191 7900", seen, dp, dm);
    end
    step();
    setup(-8100, 200, 5, 6);
    run(0, lat, dp, dm, seen);
    tests++;
    if (!seen || dp != -7900 || dm != -8192) begin
      fails++; $display("FAIL sat_neg: seen=%0d dac %0d %0d, want 1 -7900 -8192", seen, dp, dm);
    end
    step();
  endtask

  task automatic test_timeout();
    int low_cnt, rv_cnt, lat, dp, dm;
    bit seen;
    never_done = 1;
    setup(500, 20, 40, 30);
    start = 1'b1;
    step();
    start = 1'b0;
    low_cnt = 0;
    rv_cnt  = 0;
    for (int i = 0; i < 500 && busy; i++) begin
      if (!avg_rst) low_cnt++;
      if (result_valid) rv_cnt++;
      step();
    end
    tests++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || low_cnt != TO || rv_cnt != 0) begin
      fails++; $display("FAIL timeout: busy=%b te=%b avg_cycles=%0d rv=%0d, want 0 1 %0d 0",
                        busy, timeout_err, low_cnt, rv_cnt, TO);
    end
    tests++;
    if (dac_out !== 14'sd500 || avg_rst !== 1'b1 || j_plus !== 12'sd5 || j_minus !== 12'sd6) begin
      fails++; $display("FAIL timeout_outputs: dac=%0d avg_rst=%b jp=%0d jm=%0d, want 500 1 5 6",
                        dac_out, avg_rst, j_plus, j_minus);
    end
    never_done = 0;
    run(0, lat, dp, dm, seen);
    tests++;
    if (!seen || timeout_err !== 1'b0 || delta_j !== 13'sd10 || lat != LAT) begin
      fails++; $display("FAIL timeout_recover: seen=%0d te=%b dj=%0d lat=%0d, want 1 0 10 %0d",
                        seen, timeout_err, delta_j, lat, LAT);
    end
    step();
  endtask

  task automatic test_stale_extremes();
    int lat;
    bit seen;
    setup(0, 100, 2047, -2048);
    stale_done = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    lat  = 1;
    seen = 0;
    while (avg_rst && lat < 100) begin
      step(); lat++;
    end
    step(); lat++;
    step(); lat++;
    stale_done = 0;
    while (lat < 200) begin
      if (result_valid) begin
        seen = 1;
        break;
      end
      step(); lat++;
    end
    tests++;
    if (!seen || lat != LAT) begin
      fails++; $display("FAIL stale_latency: seen=%0d lat=%0d, want 1 %0d", seen, lat, LAT);
    end
    tests++;
    if (j_plus !== 12'sd2047 || j_minus !== -12'sd2048 || delta_j !== 13'sd4095) begin
      fails++; $display("FAIL stale_extremes: %0d %0d %0d, want 2047 -2048 4095", j_plus, j_minus, delta_j);
    end
    step();
  endtask

  task automatic test_busy_start();
    int lat, dp, dm;
    bit seen;
    setup(1000, 10, 300, 100);
    run(1, lat, dp, dm, seen);
    tests++;
    if (!seen || lat != LAT || dp != 1010 || dm != 990 || dac_out !== 14'sd1000) begin
      fails++; $display("FAIL busy_start: seen=%0d lat=%0d dac %0d %0d %0d, want 1 %0d 1010 990 1000",
                        seen, lat, dp, dm, dac_out, LAT);
    end
    tests++;
    if (delta_j !== 13'sd200) begin
      fails++; $display("FAIL busy_start_dj: %0d, want 200", delta_j);
    end
    step();
    tests++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || dac_out !== 14'sd1000) begin
      fails++; $display("FAIL busy_start_idle: busy=%b rv=%b dac=%0d, want 0 0 1000", busy, result_valid, dac_out);
    end
  endtask

  task automatic test_reset_in_avg_m();
    int rv_cnt;
    setup(200, 30, 11, 22);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2 * S + N + 1 + 1) step();
    tests++;
    if (avg_rst !== 1'b0 || busy !== 1'b1 || dac_out !== 14'sd170) begin
      fails++; $display("FAIL in_avg_m: avg_rst=%b busy=%b dac=%0d, want 0 1 170", avg_rst, busy, dac_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || dac_out !== 14'sd0 || avg_rst !== 1'b1 || result_valid !== 1'b0 ||
        j_plus !== 12'sd0) begin
      fails++; $display("FAIL rst_avg_m: busy=%b dac=%0d avg_rst=%b rv=%b jp=%0d, want 0 0 1 0 0",
                        busy, dac_out, avg_rst, result_valid, j_plus);
    end
    rv_cnt = 0;
    repeat (40) begin
      step();
      if (result_valid || busy) rv_cnt++;
    end
    tests++;
    if (rv_cnt != 0) begin
      fails++; $display("FAIL rst_avg_m_quiet: active cycles=%0d, want 0", rv_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    dac_base = '0; dither_amp = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_timeout();
    test_stale_extremes();
    test_busy_start();
    test_reset_in_avg_m();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
